// File: rtl/dcache_pkg.sv
// Shared Dcache constants, refill FSM state encoding and line packing helper.
package dcache_pkg;

    localparam int LINE_WORDS = 8;
    localparam int WORD_W     = 32;
    localparam int OFFSET_W   = $clog2(LINE_WORDS) + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        RD   = 2'd2,
        DONE = 2'd3
    } refill_state_e;

    // Returns the input line with word idx replaced; word i lives at [i*WORD_W +: WORD_W].
    function automatic logic [LINE_WORDS*WORD_W-1:0] line_set_word(
        input logic [LINE_WORDS*WORD_W-1:0] line,
        input int unsigned                  idx,
        input logic [WORD_W-1:0]            word
    );
        logic [LINE_WORDS*WORD_W-1:0] res;
        res = line;
        res[idx*WORD_W +: WORD_W] = word;
        return res;
    endfunction

endpackage

// File: rtl/dcache_line_buf.sv
// Refill line buffer: one synchronous word-write port, whole line readable flat.
module dcache_line_buf #(
    parameter int WORDS  = 8,
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we,
    input  logic [$clog2(WORDS)-1:0]   waddr,
    input  logic [DATA_W-1:0]          wdata,
    output logic [WORDS*DATA_W-1:0]    line
);

    logic [WORDS-1:0][DATA_W-1:0] mem_q, mem_d;

    // Next buffer contents: overwrite the addressed word on a write.
    always_comb begin
        mem_d = mem_q;
        if (we) mem_d[waddr] = wdata;
    end

    // Buffer register; reset clears any partially fetched line.
    always_ff @(posedge clk) begin
        if (rst) mem_q <= '0;
        else     mem_q <= mem_d;
    end

    assign line = mem_q;

endmodule

// File: rtl/dcache_refill_unit.sv
// Dcache miss engine: optional dirty-victim writeback, then word-by-word line fill.
module dcache_refill_unit #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         miss_req,
    input  logic [ADDR_W-1:0]            miss_addr,
    input  logic                         wb_en,
    input  logic [ADDR_W-1:0]            wb_addr,
    input  logic [LINE_WORDS*DATA_W-1:0] wb_data,
    output logic                         busy,
    output logic                         refill_done,
    output logic [LINE_WORDS*DATA_W-1:0] refill_data,
    output logic                         mem_req,
    output logic                         mem_we,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [DATA_W-1:0]            mem_wdata,
    input  logic                         mem_ack,
    input  logic [DATA_W-1:0]            mem_rdata
);
    import dcache_pkg::*;

    localparam int CNT_W = $clog2(LINE_WORDS);
    localparam int OFF_W = CNT_W + 2;
    localparam int TAG_W = ADDR_W - OFF_W;

    refill_state_e                  state_q, state_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic [TAG_W-1:0]               miss_base_q, miss_base_d;
    logic [TAG_W-1:0]               wb_base_q, wb_base_d;
    logic [LINE_WORDS-1:0][DATA_W-1:0] victim_q, victim_d;
    logic                           last_word;
    logic                           buf_we;

    assign last_word = (cnt_q == CNT_W'(LINE_WORDS - 1));

    // FSM next state, counter, latches and memory-port outputs. Outputs depend
    // only on registered state, so they are stable while waiting for mem_ack.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        miss_base_d = miss_base_q;
        wb_base_d   = wb_base_q;
        victim_d    = victim_q;
        busy        = (state_q != IDLE);
        refill_done = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        buf_we      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (miss_req) begin
                    miss_base_d = miss_addr[ADDR_W-1:OFF_W];
                    wb_base_d   = wb_addr[ADDR_W-1:OFF_W];
                    victim_d    = wb_data;
                    cnt_d       = '0;
                    state_d     = wb_en ? WB : RD;
                end
            end
            WB: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                // Offset field replaced outright: no carry into tag/index.
                mem_addr  = {wb_base_q, cnt_q, 2'b00};
                mem_wdata = victim_q[cnt_q];
                if (mem_ack) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last_word) state_d = RD;
                end
            end
            RD: begin
                mem_req  = 1'b1;
                mem_addr = {miss_base_q, cnt_q, 2'b00};
                if (mem_ack) begin
                    buf_we = 1'b1;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (last_word) state_d = DONE;
                end
            end
            DONE: begin
                refill_done = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counter and latched request registers; reset aborts any burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            miss_base_q <= '0;
            wb_base_q   <= '0;
            victim_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            miss_base_q <= miss_base_d;
            wb_base_q   <= wb_base_d;
            victim_q    <= victim_d;
        end
    end

    dcache_line_buf #(
        .WORDS  (LINE_WORDS),
        .DATA_W (DATA_W)
    ) u_line_buf (
        .clk   (clk),
        .rst   (rst),
        .we    (buf_we),
        .waddr (cnt_q),
        .wdata (mem_rdata),
        .line  (refill_data)
    );

endmodule

// File: tb/tb_dcache_refill_unit.sv
// Directed bench for dcache_refill_unit with a behavioural memory model.
module tb_dcache_refill_unit;
    import dcache_pkg::*;

    localparam logic [31:0] RD_XOR = 32'hC0DE_0000;

    logic         clk = 1'b0;
    logic         rst;
    logic         miss_req;
    logic [31:0]  miss_addr;
    logic         wb_en;
    logic [31:0]  wb_addr;
    logic [255:0] wb_data;
    logic         busy;
    logic         refill_done;
    logic [255:0] refill_data;
    logic         mem_req;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic         mem_ack;
    logic [31:0]  mem_rdata;

    int n_vec = 0;
    int n_err = 0;

    logic         t_we[$];
    logic [31:0]  t_addr[$];
    logic [31:0]  t_wdata[$];
    int           done_cyc;
    int           n_wait;
    logic [255:0] done_data;
    logic [255:0] victim_line;

    dcache_refill_unit dut (
        .clk         (clk),
        .rst         (rst),
        .miss_req    (miss_req),
        .miss_addr   (miss_addr),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .busy        (busy),
        .refill_done (refill_done),
        .refill_data (refill_data),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata)
    );

    // Memory returns a value derived from the requested address.
    assign mem_rdata = mem_addr ^ RD_XOR;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one miss, play the memory, log every completed word transfer.
    task automatic run_miss(input logic [31:0] maddr, input logic wben,
                            input logic [31:0] waddr, input logic stall,
                            input logic hold);
        logic        ack;
        logic        p_wait;
        logic        p_we;
        logic [31:0] p_addr, p_wdata;
        t_we.delete(); t_addr.delete(); t_wdata.delete();
        done_cyc = -1; n_wait = 0; done_data = '0;
        p_wait = 1'b0; p_we = 1'b0; p_addr = '0; p_wdata = '0;
        @(negedge clk);
        miss_addr = maddr; wb_en = wben; wb_addr = waddr; wb_data = victim_line;
        miss_req = 1'b1; mem_ack = 1'b1;
        @(posedge clk);                       // edge 0: acceptance
        for (int n = 1; n <= 400; n++) begin
            @(negedge clk);
            if (!hold) miss_req = 1'b0;
            if (hold && n == 3) begin
                miss_addr = 32'h7777_7777; wb_addr = 32'h3333_3333; wb_data = '1;
                wb_en = ~wben;
            end
            if (p_wait) begin
                chk("stable_req", {31'd0, mem_req}, 32'd1);
                chk("stable_we", {31'd0, mem_we}, {31'd0, p_we});
                chk("stable_addr", mem_addr, p_addr);
                chk("stable_wdata", mem_wdata, p_wdata);
            end
            if (refill_done) begin
                done_cyc = n; done_data = refill_data; miss_req = 1'b0;
                break;
            end
            ack = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            mem_ack = ack;
            if (mem_req && ack) begin
                t_we.push_back(mem_we); t_addr.push_back(mem_addr); t_wdata.push_back(mem_wdata);
            end
            if (mem_req && !ack) n_wait++;
            p_wait = mem_req && !ack; p_we = mem_we; p_addr = mem_addr; p_wdata = mem_wdata;
        end
        if (done_cyc < 0) chk("timeout", 32'd0, 32'd1);
        @(negedge clk);
        chk("busy_after_done", {31'd0, busy}, 32'd0);
        chk("done_one_cycle", {31'd0, refill_done}, 32'd0);
        wb_data = '0;
    endtask

    // Compare the logged burst, done latency and returned line to expectations.
    task automatic check_result(input string tag, input logic [31:0] maddr,
                                input logic wben, input logic [31:0] waddr);
        int          nexp;
        int          rd_idx;
        logic [31:0] mbase, wbase;
        mbase = maddr & 32'hFFFF_FFE0;
        wbase = waddr & 32'hFFFF_FFE0;
        nexp  = wben ? 16 : 8;
        chk($sformatf("%s_ntxn", tag), t_addr.size(), nexp);
        for (int k = 0; k < t_addr.size() && k < nexp; k++) begin
            if (wben && k < 8) begin
                chk($sformatf("%s_we%0d", tag, k), {31'd0, t_we[k]}, 32'd1);
                chk($sformatf("%s_waddr%0d", tag, k), t_addr[k], wbase + 32'(4 * k));
                chk($sformatf("%s_wdata%0d", tag, k), t_wdata[k], 32'hA0 + 32'(k));
            end else begin
                rd_idx = wben ? k - 8 : k;
                chk($sformatf("%s_we%0d", tag, k), {31'd0, t_we[k]}, 32'd0);
                chk($sformatf("%s_raddr%0d", tag, k), t_addr[k], mbase + 32'(4 * rd_idx));
            end
        end
        chk($sformatf("%s_done_cyc", tag), done_cyc, nexp + 1 + n_wait);
        for (int j = 0; j < 8; j++)
            chk($sformatf("%s_line%0d", tag, j), done_data[j*32 +: 32],
                (mbase + 32'(4 * j)) ^ RD_XOR);
    endtask

    initial begin
        int seen_done;
        rst = 1'b1; miss_req = 1'b0; miss_addr = '0; wb_en = 1'b0; wb_addr = '0;
        wb_data = '0; mem_ack = 1'b0;
        victim_line = '0;
        for (int i = 0; i < 8; i++) victim_line = line_set_word(victim_line, i, 32'hA0 + 32'(i));

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, refill_done}, 32'd0);
        chk("rst_data", {31'd0, |refill_data}, 32'd0);
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_we", {31'd0, mem_we}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        rst = 1'b0;

        // Clean miss, zero wait: done in cycle 9.
        run_miss(32'h0000_1234, 1'b0, 32'h0, 1'b0, 1'b0);
        check_result("clean", 32'h0000_1234, 1'b0, 32'h0);
        chk("clean_cyc9", done_cyc, 9);

        // Dirty miss, zero wait: done in cycle 17.
        run_miss(32'h0000_4000, 1'b1, 32'h0000_8000, 1'b0, 1'b0);
        check_result("dirty", 32'h0000_4000, 1'b1, 32'h0000_8000);
        chk("dirty_cyc17", done_cyc, 17);

        // Random stalls, dirty and clean.
        run_miss(32'h0000_4000, 1'b1, 32'h0000_8000, 1'b1, 1'b0);
        check_result("dirty_stall", 32'h0000_4000, 1'b1, 32'h0000_8000);
        run_miss(32'h0000_1234, 1'b0, 32'h0, 1'b1, 1'b0);
        check_result("clean_stall", 32'h0000_1234, 1'b0, 32'h0);

        // miss_req held high, inputs changed mid-burst.
        run_miss(32'h0000_4000, 1'b1, 32'h0000_8000, 1'b1, 1'b1);
        check_result("hold", 32'h0000_4000, 1'b1, 32'h0000_8000);

        // Reset during the 3rd read word.
        @(negedge clk);
        miss_addr = 32'h0000_2000; wb_en = 1'b0; miss_req = 1'b1; mem_ack = 1'b1;
        @(posedge clk);
        @(negedge clk); miss_req = 1'b0;
        @(negedge clk);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        chk("abort_req", {31'd0, mem_req}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, refill_done}, 32'd0);
        chk("abort_data", {31'd0, |refill_data}, 32'd0);
        rst = 1'b0;
        seen_done = 0;
        repeat (12) begin
            @(negedge clk);
            if (refill_done) seen_done++;
        end
        chk("abort_no_done", seen_done, 0);
        run_miss(32'h0000_1234, 1'b0, 32'h0, 1'b0, 1'b0);
        check_result("post_rst", 32'h0000_1234, 1'b0, 32'h0);

        // Top line of the address space: no wrap out of the line.
        run_miss(32'hFFFF_FFE0, 1'b0, 32'h0, 1'b0, 1'b0);
        check_result("top", 32'hFFFF_FFE0, 1'b0, 32'h0);
        if (t_addr.size() == 8) chk("top_last", t_addr[7], 32'hFFFF_FFFC);
        else chk("top_last_missing", t_addr.size(), 8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
